// File: rtl/fifo_wr_ctrl_if.sv
// fifo_wr_ctrl_if
//   Bundles the write-side signals of the FIFO write controller.
//   The write client sits on the master modport, and the controller sits on the slave modport.
//
//   Signals (all in the wr_clk domain):
//     wr_en            write request from the client
//     ovf_clr          clears the sticky overflow flag
//     rd_ptr_grey_sync read pointer (Gray), already synchronised into wr_clk
//     wr_ack           write accepted this cycle (combinational)
//     wr_addr_bin      RAM write address
//     wr_addr_grey     Gray write pointer for the read-domain synchroniser
//     full             registered full flag
//     almost_full      registered almost-full flag
//     wr_level         occupancy as seen from the write domain, 0..DEPTH
//     overflow         sticky flag: a write was attempted while full
interface fifo_wr_ctrl_if #(
  parameter int ADDR_WIDTH = 4
);
  logic                  wr_en;
  logic                  ovf_clr;
  logic [ADDR_WIDTH:0]   rd_ptr_grey_sync;
  logic                  wr_ack;
  logic [ADDR_WIDTH-1:0] wr_addr_bin;
  logic [ADDR_WIDTH:0]   wr_addr_grey;
  logic                  full;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   wr_level;
  logic                  overflow;

  // This modport is for the write client and the test environment.
  modport master (
    output wr_en,
    output ovf_clr,
    output rd_ptr_grey_sync,
    input  wr_ack,
    input  wr_addr_bin,
    input  wr_addr_grey,
    input  full,
    input  almost_full,
    input  wr_level,
    input  overflow
  );

  // This modport is for the write controller itself.
  modport slave (
    input  wr_en,
    input  ovf_clr,
    input  rd_ptr_grey_sync,
    output wr_ack,
    output wr_addr_bin,
    output wr_addr_grey,
    output full,
    output almost_full,
    output wr_level,
    output overflow
  );
endinterface

// File: rtl/fifo_wr_ctrl.sv
// fifo_wr_ctrl
//   Write-side pointer and flag logic for an asynchronous FIFO.
//   The module holds an (ADDR_WIDTH+1)-bit binary write pointer.
//   The extra MSB tells a full FIFO apart from an empty one.
//   A Gray copy of the pointer is exported for the read-domain synchroniser.
//   The module also produces full, almost_full, occupancy and a sticky overflow flag.
//   All of these are computed from the write domain's view of the read pointer.
//
//   Ports:
//     wr_clk  write-domain clock; all state updates on the rising edge
//     wr_rst  asynchronous active-low reset
//     bus     fifo_wr_ctrl_if.slave (request/ack, addresses, flags, level)
//
//   Parameters:
//     ADDR_WIDTH  RAM address width, DEPTH = 2**ADDR_WIDTH (2..12)
//     AF_MARGIN   almost_full asserts when free slots <= AF_MARGIN (1..DEPTH-1)
module fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 4,
  parameter int AF_MARGIN  = 2
) (
  input  logic                 wr_clk,
  input  logic                 wr_rst,
  fifo_wr_ctrl_if.slave        bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_THRESH = (ADDR_WIDTH + 1)'(DEPTH - AF_MARGIN);

  logic [ADDR_WIDTH:0] bin;
  logic [ADDR_WIDTH:0] bin_next;
  logic [ADDR_WIDTH:0] grey;
  logic [ADDR_WIDTH:0] grey_next;
  logic [ADDR_WIDTH:0] rd_bin;
  logic [ADDR_WIDTH:0] level_next;
  logic [ADDR_WIDTH:0] full_pattern;
  logic                full_q;
  logic                almost_full_q;
  logic [ADDR_WIDTH:0] level_q;
  logic                overflow_q;
  logic                ack;
  logic                full_next;
  logic                almost_full_next;

  // A write is accepted whenever one is requested and the FIFO is not full.
  assign ack = bus.wr_en & ~full_q;

  // This block computes the next pointer values.
  // The flags are derived from these next values rather than the current pointers.
  // That lets full rise on the same edge that writes the last free slot.
  always_comb begin
    bin_next  = bin + {{ADDR_WIDTH{1'b0}}, ack};
    grey_next = (bin_next >> 1) ^ bin_next;
  end

  // This block converts the synchronised Gray read pointer back to binary.
  // Bit i of the result is the XOR of all Gray bits from the MSB down to bit i.
  always_comb begin
    rd_bin = '0;
    for (int i = 0; i <= ADDR_WIDTH; i++) begin
      rd_bin[i] = ^(bus.rd_ptr_grey_sync >> i);
    end
  end

  // This block computes the next values of the flags and the level.
  // The write pointer is full when it equals the read pointer with its top two Gray bits inverted.
  // That is the Gray-coded form of "one full lap ahead".
  // The level subtraction wraps modulo 2**(ADDR_WIDTH+1).
  // This gives the true occupancy even after either pointer has wrapped.
  always_comb begin
    full_pattern = {~bus.rd_ptr_grey_sync[ADDR_WIDTH],
                    ~bus.rd_ptr_grey_sync[ADDR_WIDTH-1],
                    bus.rd_ptr_grey_sync[ADDR_WIDTH-2:0]};
    full_next        = (grey_next == full_pattern);
    level_next       = bin_next - rd_bin;
    almost_full_next = (level_next >= AF_THRESH);
  end

  // This block holds the pointer, flag and level registers.
  // A rejected write leaves bin_next equal to bin, so these registers keep their values.
  // They change only if the read pointer has moved.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      bin           <= '0;
      grey          <= '0;
      full_q        <= 1'b0;
      almost_full_q <= 1'b0;
      level_q       <= '0;
    end else begin
      bin           <= bin_next;
      grey          <= grey_next;
      full_q        <= full_next;
      almost_full_q <= almost_full_next;
      level_q       <= level_next;
    end
  end

  // This block holds the sticky overflow flag.
  // When a write is rejected in the same cycle as a clear, the set wins.
  // That way an overflow event is never lost.
  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      overflow_q <= 1'b0;
    end else if (bus.wr_en && full_q) begin
      overflow_q <= 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.wr_ack       = ack;
  assign bus.wr_addr_bin  = bin[ADDR_WIDTH-1:0];
  assign bus.wr_addr_grey = grey;
  assign bus.full         = full_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.wr_level     = level_q;
  assign bus.overflow     = overflow_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// tb_fifo_wr_ctrl
//   Directed testbench for fifo_wr_ctrl with ADDR_WIDTH=4 and AF_MARGIN=2.
//   The sequence is: fill to full, overflow handling, a read-pointer release,
//   a long wrap with paired reads, and an asynchronous reset in mid-burst.
module tb_fifo_wr_ctrl;

  logic wr_clk;
  logic wr_rst;
  int   checkCount;
  int   passCount;

  fifo_wr_ctrl_if #(.ADDR_WIDTH(4)) bus ();

  fifo_wr_ctrl #(
    .ADDR_WIDTH(4),
    .AF_MARGIN (2)
  ) dut (
    .wr_clk(wr_clk),
    .wr_rst(wr_rst),
    .bus   (bus)
  );

  // This block generates a free-running 10-time-unit write clock.
  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  // This task compares one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // This task drives the controller inputs and lets the combinational outputs settle.
  task automatic applyStimulus(input logic en, input logic clr, input logic [4:0] rd);
    bus.wr_en            = en;
    bus.ovf_clr          = clr;
    bus.rd_ptr_grey_sync = rd;
    #1;
  endtask

  // This task advances to just after the next rising edge.
  task automatic tick();
    @(posedge wr_clk);
    #1;
  endtask

  // This function returns the Gray code of a binary pointer value.
  function automatic logic [4:0] toGrey(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  // This function counts the set bits in a 5-bit value.
  function automatic int popCount(input logic [4:0] v);
    int n;
    n = 0;
    for (int k = 0; k < 5; k++) n += int'(v[k]);
    return n;
  endfunction

  // This task applies a clean reset and releases it between clock edges.
  task automatic doReset();
    applyStimulus(1'b0, 1'b0, 5'd0);
    wr_rst = 1'b0;
    tick();
    tick();
    @(negedge wr_clk);
    wr_rst = 1'b1;
    tick();
  endtask

  // This is the main stimulus sequence.
  initial begin
    logic [4:0] prevGrey;
    int wcnt;
    int rcnt;
    checkCount = 0;
    passCount  = 0;
    wr_rst     = 1'b1;
    applyStimulus(1'b0, 1'b0, 5'd0);

    // Hold the design in reset and check that every output is zero.
    wr_rst = 1'b0;
    #2;
    checkOutput("rst_level", 32'(bus.wr_level), 32'd0);
    checkOutput("rst_full", 32'(bus.full), 32'd0);
    checkOutput("rst_af", 32'(bus.almost_full), 32'd0);
    checkOutput("rst_ovf", 32'(bus.overflow), 32'd0);
    checkOutput("rst_addr", 32'(bus.wr_addr_bin), 32'd0);
    checkOutput("rst_grey", 32'(bus.wr_addr_grey), 32'd0);
    checkOutput("rst_ack", 32'(bus.wr_ack), 32'd0);
    doReset();

    // Write 16 words in a row.
    // almost_full should rise on the 14th write, and full on the 16th.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0);
      checkOutput("fill_ack", 32'(bus.wr_ack), 32'd1);
      checkOutput("fill_addr", 32'(bus.wr_addr_bin), 32'(i));
      tick();
      checkOutput("fill_level", 32'(bus.wr_level), 32'(i + 1));
      checkOutput("fill_af", 32'(bus.almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      checkOutput("fill_full", 32'(bus.full), (i + 1 == 16) ? 32'd1 : 32'd0);
    end
    checkOutput("fill_grey", 32'(bus.wr_addr_grey), 32'h18);

    // Attempt three writes while full.
    // They should be rejected and should set the sticky overflow flag.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0);
      checkOutput("rej_ack", 32'(bus.wr_ack), 32'd0);
      tick();
      checkOutput("rej_addr", 32'(bus.wr_addr_bin), 32'd0);
      checkOutput("rej_grey", 32'(bus.wr_addr_grey), 32'h18);
      checkOutput("rej_level", 32'(bus.wr_level), 32'd16);
      checkOutput("rej_full", 32'(bus.full), 32'd1);
      checkOutput("rej_ovf", 32'(bus.overflow), 32'd1);
    end
    applyStimulus(1'b0, 1'b1, 5'd0);
    tick();
    checkOutput("ovf_clr", 32'(bus.overflow), 32'd0);
    applyStimulus(1'b1, 1'b1, 5'd0);
    tick();
    checkOutput("ovf_set_wins", 32'(bus.overflow), 32'd1);
    checkOutput("ovf_set_level", 32'(bus.wr_level), 32'd16);

    // One read lands on the pointer input.
    // full drops one edge later, and a single write refills the FIFO.
    applyStimulus(1'b0, 1'b0, 5'b00001);
    checkOutput("rel_full_before", 32'(bus.full), 32'd1);
    tick();
    checkOutput("rel_full", 32'(bus.full), 32'd0);
    checkOutput("rel_level", 32'(bus.wr_level), 32'd15);
    checkOutput("rel_af", 32'(bus.almost_full), 32'd1);
    checkOutput("rel_ovf_sticky", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b1, 1'b0, 5'b00001);
    checkOutput("refill_ack", 32'(bus.wr_ack), 32'd1);
    checkOutput("refill_addr", 32'(bus.wr_addr_bin), 32'd0);
    tick();
    checkOutput("refill_full", 32'(bus.full), 32'd1);
    checkOutput("refill_level", 32'(bus.wr_level), 32'd16);
    checkOutput("refill_grey", 32'(bus.wr_addr_grey), 32'h19);

    // Wrap test: prime the FIFO with 3 words.
    // Then do 40 cycles where each write is paired with a read-pointer advance.
    doReset();
    wcnt = 0;
    rcnt = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0);
      tick();
      wcnt++;
    end
    checkOutput("wrap_prime_level", 32'(bus.wr_level), 32'd3);
    prevGrey = bus.wr_addr_grey;
    for (int i = 0; i < 40; i++) begin
      rcnt++;
      applyStimulus(1'b1, 1'b0, toGrey(rcnt));
      checkOutput("wrap_ack", 32'(bus.wr_ack), 32'd1);
      tick();
      wcnt++;
      checkOutput("wrap_level", 32'(bus.wr_level), 32'd3);
      checkOutput("wrap_full", 32'(bus.full), 32'd0);
      checkOutput("wrap_addr", 32'(bus.wr_addr_bin), 32'(wcnt % 16));
      checkOutput("wrap_msb", 32'(bus.wr_addr_grey[4]), 32'((wcnt >> 4) & 1));
      checkOutput("wrap_onebit", 32'(popCount(bus.wr_addr_grey ^ prevGrey)), 32'd1);
      prevGrey = bus.wr_addr_grey;
    end

    // Assert reset between clock edges after 7 writes.
    // The outputs should clear at once, and the next write should go to address 0.
    doReset();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 1'b0, 5'd0);
      tick();
    end
    checkOutput("mid_level_pre", 32'(bus.wr_level), 32'd7);
    #2;
    bus.wr_en = 1'b0;
    wr_rst    = 1'b0;
    #1;
    checkOutput("mid_addr", 32'(bus.wr_addr_bin), 32'd0);
    checkOutput("mid_grey", 32'(bus.wr_addr_grey), 32'd0);
    checkOutput("mid_level", 32'(bus.wr_level), 32'd0);
    checkOutput("mid_af", 32'(bus.almost_full), 32'd0);
    checkOutput("mid_full", 32'(bus.full), 32'd0);
    checkOutput("mid_ovf", 32'(bus.overflow), 32'd0);
    @(negedge wr_clk);
    wr_rst = 1'b1;
    tick();
    applyStimulus(1'b1, 1'b0, 5'd0);
    checkOutput("post_ack", 32'(bus.wr_ack), 32'd1);
    checkOutput("post_addr", 32'(bus.wr_addr_bin), 32'd0);
    tick();
    checkOutput("post_level", 32'(bus.wr_level), 32'd1);
    checkOutput("post_addr_next", 32'(bus.wr_addr_bin), 32'd1);
    applyStimulus(1'b0, 1'b0, 5'd0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
